// File: rtl/wb_sram_pkg.sv
// Shared types and constants for the Wishbone SRAM responder.
package wb_sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Wide enough for WAIT_STATES up to 7
    localparam int WAIT_CNT_W = 3;
    localparam int NUM_LANES  = 4;

endpackage

// File: rtl/wb_sram_if.sv
// Wishbone B3 classic bus bundle between the CPU data initiator and the SRAM responder.
interface wb_sram_if;
    import wb_sram_pkg::*;

    logic                 wb_cyc_i;
    logic                 wb_stb_i;
    logic                 wb_we_i;
    logic [31:0]          wb_adr_i;
    logic [NUM_LANES-1:0] wb_sel_i;
    logic [31:0]          wb_dat_i;
    logic [31:0]          wb_dat_o;
    logic                 wb_ack_o;
    logic                 wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

endinterface

// File: rtl/wb_sram_mem.sv
// Single-port synchronous-read SRAM, 2^ADDR_W x 32, byte write enables.
// The read register doubles as the bus read-data register, so it holds its
// value until the next read and is the only part of the memory that resets.
module wb_sram_mem
    import wb_sram_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic                 re_i,
    input  logic                 we_i,
    input  logic [NUM_LANES-1:0] be_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];
    logic [31:0] rdata_q;

    // Byte-lane writes into the array
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < NUM_LANES; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Registered read port; only updated when a read is issued
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone B3 classic responder in front of an on-chip data SRAM.
// IDLE latches the request, WAIT burns WAIT_STATES cycles, RESP terminates.
// Optional feature macro WB_SRAM_ERR_EN: out-of-range addresses and empty
// byte selects terminate with wb_err_o instead of touching memory.
module wb_sram_slave
    import wb_sram_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic     wb_clk_i,
    input  logic     wb_rst_i,
    wb_sram_if.slave wb
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        WAIT_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]       adr_q;
    logic                    we_q;
    logic [NUM_LANES-1:0]    sel_q;
    logic [31:0]             dat_q;
    logic                    err_q;

    logic                    req;
    logic                    req_err;
    logic [ADDR_W-1:0]       mem_addr;
    logic                    mem_re;
    logic                    mem_we;
    logic                    unused_adr;

    assign req = wb.wb_cyc_i & wb.wb_stb_i;

`ifdef WB_SRAM_ERR_EN
    assign req_err = (wb.wb_adr_i[27:ADDR_W+2] != '0) || (wb.wb_sel_i == '0);
`else
    assign req_err = 1'b0;
`endif

    // Address bits outside the word index are intentionally don't-care
    assign unused_adr = ^wb.wb_adr_i;

    // State and wait counter registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request attributes are captured only when a request is accepted in IDLE
    always_ff @(posedge wb_clk_i) begin
        if (state_q == ST_IDLE && req) begin
            adr_q <= wb.wb_adr_i[ADDR_W+1:2];
            we_q  <= wb.wb_we_i;
            sel_q <= wb.wb_sel_i;
            dat_q <= wb.wb_dat_i;
            err_q <= req_err;
        end
    end

    // Next-state logic; dropping cyc while waiting abandons the transfer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (!wb.wb_cyc_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs and memory strobes: the read is launched in the cycle before
    // RESP so the registered data lines up with ack; writes land at the end
    // of RESP. With no wait states that cycle is IDLE, so the live address
    // feeds the memory directly.
    always_comb begin
        wb.wb_ack_o = 1'b0;
        wb.wb_err_o = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = adr_q;
        if (state_q == ST_RESP) begin
            wb.wb_ack_o = ~err_q;
            wb.wb_err_o = err_q;
            mem_we      = we_q & ~err_q;
        end else if (state_d == ST_RESP) begin
            if (state_q == ST_IDLE) begin
                mem_addr = wb.wb_adr_i[ADDR_W+1:2];
                mem_re   = ~wb.wb_we_i & ~req_err;
            end else begin
                mem_re   = ~we_q & ~err_q;
            end
        end
    end

    wb_sram_mem #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rst_i),
        .addr_i  (mem_addr),
        .re_i    (mem_re),
        .we_i    (mem_we),
        .be_i    (sel_q),
        .wdata_i (dat_q),
        .rdata_o (wb.wb_dat_o)
    );

endmodule

// File: tb/tb_wb_sram_slave.sv
// Scoreboard bench for wb_sram_slave: the driver predicts each termination
// (kind, cycle, read data) from a word-array model and queues it; a monitor
// on the falling edge pops and compares whenever ack or err is seen.
module tb_wb_sram_slave;

    localparam int ADDR_W = 12;
    localparam int WS     = 1;

    typedef struct {
        bit          err;
        logic [31:0] dat;
        int          when;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_sram_if bus();

    wb_sram_slave #(
        .ADDR_W      (ADDR_W),
        .WAIT_STATES (WS)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .wb       (bus)
    );

    logic [31:0] ref_mem [4096];
    logic [31:0] last_rd = 32'h0;
    exp_t        expq[$];
    int          pc = 0;
    int          free_pc = 0;
    int          total = 0;
    int          bad = 0;

    always @(posedge clk) pc <= pc + 1;

    function automatic bit ref_err(input logic [31:0] adr, input logic [3:0] sel);
`ifdef WB_SRAM_ERR_EN
        return ((adr & 32'h0FFF_FFFF) >= 32'(4 << ADDR_W)) || (sel == 4'h0);
`else
        return (adr == adr + 32'd1) && (sel == 4'hF);
`endif
    endfunction

    function automatic int ref_idx(input logic [31:0] adr);
        return int'((adr >> 2) % (32'd1 << ADDR_W));
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] m = 32'h0;
        for (int b = 0; b < 4; b++) if (sel[b]) m = m | (32'hFF << (8 * b));
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // One complete transfer; returns once the DUT terminates it
    task automatic xfer(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat);
        exp_t e;
        int   acc;
        bit   seen = 1'b0;
        @(negedge clk);
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
        bus.wb_adr_i = adr;  bus.wb_sel_i = sel;  bus.wb_dat_i = dat;
        acc   = (pc + 1 > free_pc) ? pc + 1 : free_pc;
        e.err = ref_err(adr, sel);
        if (!e.err) begin
            if (we) ref_mem[ref_idx(adr)] = (ref_mem[ref_idx(adr)] & ~lane_mask(sel))
                                          | (dat & lane_mask(sel));
            else    last_rd = ref_mem[ref_idx(adr)];
        end
        e.dat  = last_rd;
        e.when = acc + WS;
        expq.push_back(e);
        free_pc = e.when + 2;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            if (bus.wb_ack_o || bus.wb_err_o) seen = 1'b1;
            else if (pc >= acc) begin
                bus.wb_adr_i = $urandom; bus.wb_dat_i = $urandom;
                bus.wb_sel_i = 4'($urandom); bus.wb_we_i = 1'($urandom);
            end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL xfer_timeout: adr %h got no termination expected one at cycle %0d", adr, e.when);
        end
        bus.wb_stb_i = 1'b0;
        bus.wb_cyc_i = 1'($urandom);
    endtask

    // Write whose cycle is abandoned while the responder is waiting
    task automatic abort_write(input logic [31:0] adr, input logic [31:0] dat);
        int acc;
        @(negedge clk);
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
        bus.wb_adr_i = adr;  bus.wb_sel_i = 4'hF; bus.wb_dat_i = dat;
        acc = (pc + 1 > free_pc) ? pc + 1 : free_pc;
        for (int i = 0; i < 10 && pc < acc; i++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        free_pc = acc + 2;
        repeat (3) @(negedge clk);
    endtask

    // Write that is interrupted by reset while its response is on the bus
    task automatic reset_in_resp(input logic [31:0] adr, input logic [31:0] dat);
        bit seen = 1'b0;
        @(negedge clk);
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
        bus.wb_adr_i = adr;  bus.wb_sel_i = 4'hF; bus.wb_dat_i = dat;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            seen = bus.wb_ack_o;
        end
        rst_n = 1'b0;
        #1;
        check("rst_resp_reached", 32'(seen), 32'd1);
        check("rst_resp_ack", 32'(bus.wb_ack_o), 32'd0);
        check("rst_resp_err", 32'(bus.wb_err_o), 32'd0);
        check("rst_resp_dat", bus.wb_dat_o, 32'h0);
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        last_rd = 32'h0;
        free_pc = 0;
    endtask

    // Monitor: every termination must match the oldest prediction
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && (bus.wb_ack_o || bus.wb_err_o)) begin
            if (expq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_term: ack=%0b err=%0b at cycle %0d, none expected",
                         bus.wb_ack_o, bus.wb_err_o, pc);
            end else begin
                e = expq.pop_front();
                total++;
                if (bus.wb_err_o !== e.err || bus.wb_ack_o !== !e.err) begin
                    bad++;
                    $display("FAIL term_kind: ack=%0b err=%0b expected err=%0b",
                             bus.wb_ack_o, bus.wb_err_o, e.err);
                end
                total++;
                if (pc != e.when) begin
                    bad++;
                    $display("FAIL latency: terminated at cycle %0d expected %0d", pc, e.when);
                end
                total++;
                if (bus.wb_dat_o !== e.dat) begin
                    bad++;
                    $display("FAIL rdata: got %h expected %h", bus.wb_dat_o, e.dat);
                end
            end
        end
    end

    initial begin
        logic [31:0] adr;
        logic [3:0]  sel;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        bus.wb_adr_i = '0;   bus.wb_sel_i = '0;   bus.wb_dat_i = '0;
        repeat (3) @(negedge clk);
        check("in_reset_ack", 32'(bus.wb_ack_o), 32'd0);
        check("in_reset_err", 32'(bus.wb_err_o), 32'd0);
        check("in_reset_dat", bus.wb_dat_o, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_ack", 32'(bus.wb_ack_o), 32'd0);
        check("post_reset_dat", bus.wb_dat_o, 32'h0);

        for (int i = 0; i < 16; i++) xfer(1'b1, 32'(i * 4), 4'hF, $urandom);

        xfer(1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
        xfer(1'b0, 32'h0000_0010, 4'hF, 32'h0);
        xfer(1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344);
        xfer(1'b1, 32'h0000_0020, 4'b0101, 32'hAABB_CCDD);
        xfer(1'b0, 32'h0000_0020, 4'hF, 32'h0);
        xfer(1'b0, 32'h0000_0000, 4'hF, 32'h0);
        xfer(1'b0, 32'h0000_0004, 4'hF, 32'h0);
        if (WS > 0) abort_write(32'h0000_0010, 32'h5555_5555);
        xfer(1'b0, 32'h0000_0010, 4'hF, 32'h0);
        reset_in_resp(32'h0000_000C, 32'h1234_5678);
        xfer(1'b0, 32'h0000_000C, 4'hF, 32'h0);
        xfer(1'b0, 32'h0000_4000, 4'hF, 32'h0);
        xfer(1'b1, 32'h0000_0008, 4'h0, 32'hFFFF_FFFF);
        xfer(1'b0, 32'h0000_0008, 4'hF, 32'h0);

        for (int n = 0; n < 80; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            adr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) adr = adr | (32'($urandom_range(1, 16383)) << 14);
            adr = adr | (32'($urandom_range(0, 15)) << 28);
            sel = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            xfer(1'($urandom), adr, sel, $urandom);
        end

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_sram_slave.md
# wb_sram_slave

Wishbone B3 classic-cycle responder that fronts a single-port on-chip data SRAM with byte-lane writes and a configurable number of wait states. It hangs off one slave port of the Wishbone interconnect and serves load/store traffic from the CPU data-side Wishbone initiator. It is the responder end of the same bus the CPU drives.

## Interface
- ADDR_W, 12, word-address width; memory holds 2^ADDR_W 32-bit words
- WAIT_STATES, 1, extra cycles inserted before ack; legal 0..7
- wb_clk_i  in  1  bus clock; all state on rising edge
- wb_rst_i  in  1  reset, asynchronous, active-low
- wb_cyc_i  in  1  bus cycle in progress
- wb_stb_i  in  1  strobe; transfer request valid
- wb_we_i  in  1  1 = write, 0 = read
- wb_adr_i  in  32  byte address; [ADDR_W+1:2] selects word, [1:0] ignored
- wb_sel_i  in  4  byte-lane enables; sel[n] covers dat[8n+7:8n]
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data
- wb_ack_o  out  1  normal termination
- wb_err_o  out  1  error termination (see Configuration)

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: on cyc&stb sampled high, latch adr/we/sel/dat; go WAIT if WAIT_STATES>0 (load counter with WAIT_STATES-1), else RESP.
- WAIT: decrement counter each cycle; at 0 go RESP. If cyc drops, go IDLE: no write performed, no ack.
- RESP: assert exactly one of ack/err for one cycle; go IDLE. Writes commit to SRAM on the RESP edge, only lanes with sel set. Reads: SRAM read issued on entry to RESP-1 so wb_dat_o is valid during RESP.
- After RESP, IDLE lasts at least one cycle: back-to-back strobes see ack separated by one low cycle (initiator drops stb on ack).
- wb_dat_o holds last read word until next read completes; unchanged by writes.
- Write with sel=0000 (feature out): ack, memory unchanged.
- cyc high with stb low: stays IDLE.
- Request attributes are latched in IDLE; input changes during WAIT/RESP are ignored.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, counter 0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0. SRAM contents not reset.
- Reset during WAIT/RESP: outputs clear immediately; pending write dropped.
- Latency: stb sampled at edge N -> ack high in cycle N+1+WAIT_STATES, for one cycle.
- Throughput: one transfer per WAIT_STATES+2 cycles.
- Read data and ack asserted in the same cycle; no combinational path from inputs to outputs.

## Configuration
- WB_SRAM_ERR_EN defined: request whose wb_adr_i[27:ADDR_W+2] is non-zero, or whose sel is 0000, terminates with wb_err_o instead of wb_ack_o at the same cycle; no memory access, wb_dat_o unchanged.
- Not defined: upper address bits ignored (aliasing modulo memory size), every request acks, wb_err_o tied 0.

## Structure
- Package wb_sram_pkg: FSM state enum, WAIT_CNT_W constant (3), byte-lane count (4).
- Sub-module wb_sram_mem: single-port synchronous-read RAM, 2^ADDR_W x 32, per-byte write enables; inferable as block RAM. Top holds FSM, counter, latches, decode.

## Test plan
- WAIT_STATES=1: write 0xDEADBEEF to 0x0000_0010 sel=1111, read back -> ack 2 cycles after stb sample, wb_dat_o=0xDEADBEEF.
- Byte lanes: write 0x11223344 full, then 0xAABBCCDD sel=0101 -> read returns 0x11BB33DD.
- WAIT_STATES=0: back-to-back reads at 0x0,0x4 -> acks at cycles N+1 and N+3, one low cycle between.
- Abort: cyc dropped during WAIT on write of 0x5555_5555 -> no ack, later read returns old value.
- Reset asserted in RESP -> ack/err/dat_o 0 same cycle; after release prior contents still readable.
- WB_SRAM_ERR_EN, ADDR_W=12: read 0x0000_4000 -> wb_err_o one cycle, no ack; without macro same access acks and returns word 0.
